branch_predict_unit: RTL and testbench

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/branch_predict_unit.sv | 202 ++++++++++++++++++++
 tb/tb_branch_predict_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
//   Dynamic branch predictor with a direct-mapped branch history table and
//   branch target buffer. It also resolves branches in the EX stage.
//
//   Fetch side
//     The fetch PC indexes the tables. When the entry is valid, its tag
//     matches and the counter MSB is set, the unit predicts taken and
//     supplies the stored target.
//
//   EX side
//     The unit resolves the branch condition on the forwarded operands. It
//     detects a mispredict against the prediction carried down the pipe and
//     produces the correct next PC. It also trains the tables and keeps
//     saturating statistics.
//
//   Ports
//     clk, rst                     clock, synchronous active-high reset
//     pc_f                         fetch PC
//     pred_taken_f, pred_target_f  fetch prediction (target 0 if not taken)
//     ex_valid, ex_pc              EX instruction valid and PC
//     ex_reg1, ex_reg2             forwarded rs1/rs2 operands
//     ex_br_type                   branch type code (see BT_* below)
//     ex_target                    computed branch target
//     ex_pred_taken/_target        prediction made at fetch
//     ex_br                        resolved taken
//     ex_mispredict                redirect required
//     ex_redirect_pc               correct next PC
//     br_cnt, mispred_cnt          resolved-branch / mispredict counts
//
//   Branch type encoding
//     NOBRANCH=0, BEQ=1, BNE=2, BLT=3, BLTU=4, BGE=5, BGEU=6. Code 7 is
//     undefined.
// ---------------------------------------------------------------------------
module branch_predict_unit #(
  parameter int XLEN       = 32,
  parameter int ENTRIES    = 64,
  parameter int PREDICT_EN = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pc_f,
  output logic             pred_taken_f,
  output logic [XLEN-1:0]  pred_target_f,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_reg1,
  input  logic [XLEN-1:0]  ex_reg2,
  input  logic [2:0]       ex_br_type,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  output logic             ex_br,
  output logic             ex_mispredict,
  output logic [XLEN-1:0]  ex_redirect_pc,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam logic [2:0] BT_NOBRANCH = 3'd0;
  localparam logic [2:0] BT_BEQ      = 3'd1;
  localparam logic [2:0] BT_BNE      = 3'd2;
  localparam logic [2:0] BT_BLT      = 3'd3;
  localparam logic [2:0] BT_BLTU     = 3'd4;
  localparam logic [2:0] BT_BGE      = 3'd5;
  localparam logic [2:0] BT_BGEU     = 3'd6;

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_ST  = 2'd3;

  localparam logic PRED_ON = (PREDICT_EN != 0);

  // Table storage
  logic [ENTRIES-1:0] r_valid;
  logic [1:0]         r_ctr    [ENTRIES];
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [XLEN-1:0]    r_target [ENTRIES];

  logic [CNT_W-1:0]   r_br_cnt;
  logic [CNT_W-1:0]   r_mispred_cnt;

  logic [IDX_W-1:0]   w_f_idx;
  logic [TAG_W-1:0]   w_f_tag;
  logic [IDX_W-1:0]   w_ex_idx;
  logic [TAG_W-1:0]   w_ex_tag;
  logic               w_br;
  logic               w_is_branch;
  logic               w_upd;
  logic               w_mispredict;
  logic               w_unused;

  assign w_f_idx  = pc_f[IDX_W+1:2];
  assign w_f_tag  = pc_f[XLEN-1:IDX_W+2];
  assign w_ex_idx = ex_pc[IDX_W+1:2];
  assign w_ex_tag = ex_pc[XLEN-1:IDX_W+2];

  // The low PC bits are implied by 4-byte alignment.
  assign w_unused = &{1'b0, pc_f[1:0], ex_pc[1:0]};

  // Fetch prediction: reads the table contents from before any update in
  // this cycle. The update lands at the edge.
  always_comb begin
    pred_taken_f  = 1'b0;
    pred_target_f = {XLEN{1'b0}};
    if (PRED_ON && r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag) &&
        r_ctr[w_f_idx][1]) begin
      pred_taken_f  = 1'b1;
      pred_target_f = r_target[w_f_idx];
    end else begin
      pred_taken_f  = 1'b0;
      pred_target_f = {XLEN{1'b0}};
    end
  end

  // Branch condition resolution and branch-type decode
  always_comb begin
    w_br        = 1'b0;
    w_is_branch = 1'b0;
    case (ex_br_type)
      BT_BEQ:  begin w_is_branch = 1'b1; w_br = (ex_reg1 == ex_reg2); end
      BT_BNE:  begin w_is_branch = 1'b1; w_br = (ex_reg1 != ex_reg2); end
      BT_BLT:  begin w_is_branch = 1'b1; w_br = ($signed(ex_reg1) <  $signed(ex_reg2)); end
      BT_BLTU: begin w_is_branch = 1'b1; w_br = (ex_reg1 <  ex_reg2); end
      BT_BGE:  begin w_is_branch = 1'b1; w_br = ($signed(ex_reg1) >= $signed(ex_reg2)); end
      BT_BGEU: begin w_is_branch = 1'b1; w_br = (ex_reg1 >= ex_reg2); end
      BT_NOBRANCH: begin w_is_branch = 1'b0; w_br = 1'b0; end
      default: begin w_is_branch = 1'b0; w_br = 1'b0; end
    endcase
    if (!ex_valid) begin
      w_br = 1'b0;
    end else begin
      w_br = w_br;
    end
  end

  assign w_upd = ex_valid & w_is_branch;

  // Mispredict when the direction is wrong, or when the branch is taken but
  // the carried target is stale.
  always_comb begin
    w_mispredict = 1'b0;
    if (w_upd) begin
      w_mispredict = (w_br != ex_pred_taken) ||
                     (w_br && (ex_pred_target != ex_target));
    end else begin
      w_mispredict = 1'b0;
    end
  end

  assign ex_br          = w_br;
  assign ex_mispredict  = w_mispredict;
  assign ex_redirect_pc = w_br ? ex_target : (ex_pc + {{(XLEN-3){1'b0}}, 3'd4});
  assign br_cnt         = r_br_cnt;
  assign mispred_cnt    = r_mispred_cnt;

  // Valid bits and 2-bit saturating counters (reset: invalid, weakly not-taken)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= {ENTRIES{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        r_ctr[i] <= CTR_WNT;
      end
    end else if (w_upd) begin
      if (w_br) begin
        r_valid[w_ex_idx] <= 1'b1;
        if (r_ctr[w_ex_idx] != CTR_ST) begin
          r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
        end
      end else if (r_ctr[w_ex_idx] != 2'd0) begin
        r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
      end
    end
  end

  // Tag and target payload: written only by taken updates, so needs no reset
  always_ff @(posedge clk) begin
    if (!rst && w_upd && w_br) begin
      r_tag[w_ex_idx]    <= w_ex_tag;
      r_target[w_ex_idx] <= ex_target;
    end
  end

  // Saturating statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_cnt      <= {CNT_W{1'b0}};
      r_mispred_cnt <= {CNT_W{1'b0}};
    end else if (w_upd) begin
      if (r_br_cnt != {CNT_W{1'b1}}) begin
        r_br_cnt <= r_br_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_mispredict && (r_mispred_cnt != {CNT_W{1'b1}})) begin
        r_mispred_cnt <= r_mispred_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

  localparam logic [2:0] T_NOB  = 3'd0;
  localparam logic [2:0] T_BEQ  = 3'd1;
  localparam logic [2:0] T_BNE  = 3'd2;
  localparam logic [2:0] T_BLT  = 3'd3;
  localparam logic [2:0] T_BLTU = 3'd4;
  localparam logic [2:0] T_BGE  = 3'd5;
  localparam logic [2:0] T_BGEU = 3'd6;
  localparam logic [2:0] T_UND  = 3'd7;

  logic        clk;
  logic        rst;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_reg1;
  logic [31:0] ex_reg2;
  logic [2:0]  ex_br_type;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        ex_br;
  logic        ex_mispredict;
  logic [31:0] ex_redirect_pc;
  logic [31:0] br_cnt;
  logic [31:0] mispred_cnt;

  int n_vec = 0;
  int n_err = 0;

  branch_predict_unit dut (
    .clk(clk), .rst(rst), .pc_f(pc_f),
    .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_reg1(ex_reg1), .ex_reg2(ex_reg2),
    .ex_br_type(ex_br_type), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .ex_br(ex_br), .ex_mispredict(ex_mispredict),
    .ex_redirect_pc(ex_redirect_pc), .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive all EX inputs at once.
  task automatic drive_ex(input logic v, input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] pc,
                          input logic [31:0] tgt, input logic pt, input logic [31:0] ptt);
    ex_valid = v; ex_br_type = t; ex_reg1 = a; ex_reg2 = b; ex_pc = pc;
    ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptt;
  endtask

  task automatic test_reset;
    rst = 1'b1; pc_f = 32'h100;
    drive_ex(1'b0, T_NOB, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    n_vec++; if (pred_taken_f !== 1'b0) begin n_err++; $display("FAIL reset_pred: got %b exp 0", pred_taken_f); end
    n_vec++; if (pred_target_f !== 32'h0) begin n_err++; $display("FAIL reset_tgt: got %h exp 0", pred_target_f); end
    n_vec++; if (br_cnt !== 32'h0) begin n_err++; $display("FAIL reset_brcnt: got %0d exp 0", br_cnt); end
    n_vec++; if (mispred_cnt !== 32'h0) begin n_err++; $display("FAIL reset_mpcnt: got %0d exp 0", mispred_cnt); end
  endtask

  // Update presented while rst=1 must be discarded.
  task automatic test_update_in_reset;
    @(negedge clk);
    rst = 1'b1;
    drive_ex(1'b1, T_BEQ, 32'h7, 32'h7, 32'h100, 32'h80, 1'b0, 32'h0);
    #1;
    n_vec++; if (ex_br !== 1'b1) begin n_err++; $display("FAIL rst_comb_br: got %b exp 1", ex_br); end
    @(negedge clk);
    rst = 1'b0; ex_valid = 1'b0; pc_f = 32'h100; #1;
    n_vec++; if (pred_taken_f !== 1'b0) begin n_err++; $display("FAIL rst_upd_pred: got %b exp 0", pred_taken_f); end
    n_vec++; if (br_cnt !== 32'h0) begin n_err++; $display("FAIL rst_upd_brcnt: got %0d exp 0", br_cnt); end
  endtask

  // Combinational branch resolution; ex_valid dropped before the edge.
  task automatic test_compare;
    logic [2:0]  t   [10] = '{T_BLT, T_BLTU, T_BEQ, T_BNE, T_BGE, T_BGEU, T_NOB, T_UND, T_BNE, T_BGE};
    logic [31:0] a   [10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5, 32'h5, 32'h1, 32'h1, 32'h5, 32'h5, 32'h5, 32'h80000000};
    logic [31:0] b   [10] = '{32'h1, 32'h1, 32'h5, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5, 32'h5, 32'h6, 32'h7FFFFFFF};
    logic        exp [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive_ex(1'b1, t[i], a[i], b[i], 32'h40, 32'h400, 1'b0, 32'h0); #1;
      n_vec++; if (ex_br !== exp[i]) begin n_err++; $display("FAIL cmp%0d: got %b exp %b", i, ex_br, exp[i]); end
      n_vec++; if (ex_redirect_pc !== (exp[i] ? 32'h400 : 32'h44)) begin n_err++; $display("FAIL redir%0d: got %h", i, ex_redirect_pc); end
      ex_valid = 1'b0;
    end
    @(negedge clk);
    drive_ex(1'b0, T_BEQ, 32'h5, 32'h5, 32'hFFFFFFFC, 32'h400, 1'b0, 32'h0); #1;
    n_vec++; if (ex_br !== 1'b0) begin n_err++; $display("FAIL invalid_br: got %b exp 0", ex_br); end
    n_vec++; if (ex_redirect_pc !== 32'h0) begin n_err++; $display("FAIL wrap_redir: got %h exp 0", ex_redirect_pc); end
    n_vec++; if (ex_mispredict !== 1'b0) begin n_err++; $display("FAIL invalid_mp: got %b exp 0", ex_mispredict); end
    @(negedge clk); #1;
    n_vec++; if (br_cnt !== 32'h0) begin n_err++; $display("FAIL cmp_brcnt: got %0d exp 0", br_cnt); end
  endtask

  // Taken update trains BTB; same-cycle fetch sees old contents.
  task automatic test_taken_update;
    @(negedge clk);
    pc_f = 32'h100;
    drive_ex(1'b1, T_BEQ, 32'h7, 32'h7, 32'h100, 32'h80, 1'b0, 32'h0); #1;
    n_vec++; if (ex_mispredict !== 1'b1) begin n_err++; $display("FAIL tk_mp: got %b exp 1", ex_mispredict); end
    n_vec++; if (ex_redirect_pc !== 32'h80) begin n_err++; $display("FAIL tk_redir: got %h exp 80", ex_redirect_pc); end
    n_vec++; if (pred_taken_f !== 1'b0) begin n_err++; $display("FAIL tk_bypass: got %b exp 0", pred_taken_f); end
    @(negedge clk);
    ex_valid = 1'b0; #1;
    n_vec++; if (pred_taken_f !== 1'b1) begin n_err++; $display("FAIL tk_pred: got %b exp 1", pred_taken_f); end
    n_vec++; if (pred_target_f !== 32'h80) begin n_err++; $display("FAIL tk_tgt: got %h exp 80", pred_target_f); end
    n_vec++; if (br_cnt !== 32'd1) begin n_err++; $display("FAIL tk_brcnt: got %0d exp 1", br_cnt); end
    n_vec++; if (mispred_cnt !== 32'd1) begin n_err++; $display("FAIL tk_mpcnt: got %0d exp 1", mispred_cnt); end
  endtask

  task automatic test_alias;
    @(negedge clk);
    pc_f = 32'h200; #1;
    n_vec++; if (pred_taken_f !== 1'b0) begin n_err++; $display("FAIL alias_pred: got %b exp 0", pred_taken_f); end
    n_vec++; if (pred_target_f !== 32'h0) begin n_err++; $display("FAIL alias_tgt: got %h exp 0", pred_target_f); end
    pc_f = 32'h100;
  endtask

  // Correct prediction (ctr 2->3), then 4 not-taken (3->0, saturating),
  // then 2 taken (0->2).
  task automatic test_saturate;
    logic [2:0]  t   [7] = '{T_BEQ, T_BNE, T_BNE, T_BNE, T_BNE, T_BEQ, T_BEQ};
    logic        pt  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        emp [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        ep  [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      pc_f = 32'h100;
      drive_ex(1'b1, t[i], 32'h9, 32'h9, 32'h100, 32'h80, pt[i], 32'h80); #1;
      n_vec++; if (ex_mispredict !== emp[i]) begin n_err++; $display("FAIL sat_mp%0d: got %b exp %b", i, ex_mispredict, emp[i]); end
      @(negedge clk);
      ex_valid = 1'b0; #1;
      n_vec++; if (pred_taken_f !== ep[i]) begin n_err++; $display("FAIL sat_pred%0d: got %b exp %b", i, pred_taken_f, ep[i]); end
    end
    n_vec++; if (br_cnt !== 32'd8) begin n_err++; $display("FAIL sat_brcnt: got %0d exp 8", br_cnt); end
    n_vec++; if (mispred_cnt !== 32'd7) begin n_err++; $display("FAIL sat_mpcnt: got %0d exp 7", mispred_cnt); end
  endtask

  // Right direction, stale target: mispredict.
  task automatic test_wrong_target;
    @(negedge clk);
    drive_ex(1'b1, T_BGEU, 32'h9, 32'h3, 32'h100, 32'h80, 1'b1, 32'h84); #1;
    n_vec++; if (ex_mispredict !== 1'b1) begin n_err++; $display("FAIL wt_mp: got %b exp 1", ex_mispredict); end
    @(negedge clk);
    ex_valid = 1'b0; #1;
    n_vec++; if (mispred_cnt !== 32'd8) begin n_err++; $display("FAIL wt_mpcnt: got %0d exp 8", mispred_cnt); end
    n_vec++; if (br_cnt !== 32'd9) begin n_err++; $display("FAIL wt_brcnt: got %0d exp 9", br_cnt); end
  endtask

  initial begin
    test_reset();
    test_update_in_reset();
    test_compare();
    test_taken_update();
    test_alias();
    test_saturate();
    test_wrong_target();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
